// File: rtl/bcd_6bit_seq_ctrl.sv
// ============================================================================
// Module   : bcd_6bit_seq_ctrl
// Brief    : Serial binary-to-BCD converter (shift-and-add-3, one bit/clock)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_6bit_seq_ctrl #(
  parameter int W  = 6,
  parameter int ND = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    A,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] B
);

  localparam int     CW     = $clog2(W + 1);
  localparam longint MAXV   = (longint'(1) << W) - 1;
  localparam longint DECCAP = longint'(10) ** ND;

  // Every W-bit value must fit in ND decimal digits.
  if (DECCAP <= MAXV) begin : g_bad_params
    $error("bcd_6bit_seq_ctrl: ND too small for W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [W-1:0]      r_bin;
  logic [4*ND-1:0]   r_bcd;
  logic              r_busy;
  logic              r_done;
  logic [4*ND-1:0]   r_b;

  logic [4*ND-1:0]   w_adj;
  logic [4*ND-1:0]   w_bcd_nxt;
  logic [W-1:0]      w_bin_nxt;

  for (genvar d = 0; d < ND; d++) begin : g_digit
    assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                        : r_bcd[4*d +: 4];
  end

  assign w_bcd_nxt = {w_adj[4*ND-2:0], r_bin[W-1]};
  assign w_bin_nxt = {r_bin[W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin   <= A;
            r_bcd   <= '0;
            r_cnt   <= CW'(W);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Last shift: publish the result including this step directly.
          if (r_cnt == CW'(1)) begin
            r_b     <= w_bcd_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign B    = r_b;

endmodule

`default_nettype wire
